// File: rtl/multicycle_alu.sv
// Handshaked ALU with registered results: single-cycle arithmetic/logic/shift ops,
// plus iterative unsigned shift-add multiply and restoring divide.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [4:0]       flags_out
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;
  localparam logic [3:0] OP_CB   = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ASR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_out_hi;
  logic [4:0]       r_flags;
  logic [SHW-1:0]   r_cnt;
  logic             r_mul;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_b;

  // Single-cycle datapath, evaluated directly from the request inputs.
  logic [SHW-1:0]   w_n;
  logic [SHW-1:0]   w_bit;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_shr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_opb;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  logic             w_c;
  logic             w_v;
  logic             w_dz;
  logic [4:0]       w_flags;
  logic             w_multi;

  assign w_n    = in_b[SHW-1:0];
  assign w_bit  = in_a[SHW-1:0];
  assign w_mask = WIDTH'(1) << w_bit;
  assign w_shl  = {1'b0, in_a} << w_n;
  assign w_shr  = {in_a, 1'b0} >> w_n;
  assign w_asr  = $signed({in_a, 1'b0}) >>> w_n;
  assign w_multi = (op == OP_MUL) || ((op == OP_DIVU) && (in_b != '0));

  always_comb begin
    w_opb = in_b;
    w_sub = 1'b0;
    w_sum = '0;
    w_res = '0;
    w_hi  = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_dz  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC: begin
        w_sub = (op == OP_SUB) || (op == OP_CMP) || (op == OP_DEC);
        w_opb = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : in_b;
        w_sum = w_sub ? ({1'b0, in_a} - {1'b0, w_opb}) : ({1'b0, in_a} + {1'b0, w_opb});
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_sub ? ((in_a[MSB] != w_opb[MSB]) && (w_res[MSB] != in_a[MSB]))
                      : ((in_a[MSB] == w_opb[MSB]) && (w_res[MSB] != in_a[MSB]));
      end
      OP_AND:  w_res = in_a & in_b;
      OP_OR:   w_res = in_a | in_b;
      OP_XOR:  w_res = in_a ^ in_b;
      OP_SB:   w_res = in_b | w_mask;
      OP_CB:   w_res = in_b & ~w_mask;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_ASR: begin
        w_res = w_asr[WIDTH:1];
        w_c   = w_asr[0];
      end
      OP_DIVU: begin
        // Only the divide-by-zero case completes here; real divides iterate.
        w_res = '1;
        w_hi  = in_a;
        w_dz  = 1'b1;
      end
      OP_PASS: w_res = in_b;
      default: w_res = '0;
    endcase
    w_flags = {w_dz, w_v, w_c, w_res[MSB], (w_res == '0)};
  end

  // One iteration of the shared multiply/divide engine.
  // MUL: r_y = partial high half, r_x = multiplier shifting out as product low half.
  // DIVU: r_y = partial remainder, r_x = dividend shifting out as quotient shifts in.
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dsh;
  logic [WIDTH+1:0] w_ddiff;
  logic             w_dok;
  logic [WIDTH-1:0] w_it_lo;
  logic [WIDTH-1:0] w_it_hi;
  logic             w_mov;

  assign w_msum  = {1'b0, r_y} + (r_x[0] ? {1'b0, r_b} : '0);
  assign w_dsh   = {r_y, r_x[MSB]};
  assign w_ddiff = {1'b0, w_dsh} - {2'b00, r_b};
  assign w_dok   = ~w_ddiff[WIDTH+1];
  assign w_it_lo = r_mul ? {w_msum[0], r_x[WIDTH-1:1]} : {r_x[WIDTH-2:0], w_dok};
  assign w_it_hi = r_mul ? w_msum[WIDTH:1] : (w_dok ? w_ddiff[WIDTH-1:0] : w_dsh[WIDTH-1:0]);
  assign w_mov   = r_mul && (w_it_hi != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_hi    <= '0;
      r_flags     <= '0;
      r_cnt       <= '0;
      r_mul       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_b         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush && in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (w_multi) begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_INIT;
              r_mul   <= (op == OP_MUL);
              r_x     <= in_a;
              r_y     <= '0;
              r_b     <= in_b;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out       <= w_res;
              r_out_hi    <= w_hi;
              r_flags     <= w_flags;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_BUSY: begin
          if (flush) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_x <= w_it_lo;
            r_y <= w_it_hi;
            if (r_cnt == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out       <= w_it_lo;
              r_out_hi    <= w_it_hi;
              r_flags     <= {1'b0, w_mov, w_mov, w_it_lo[MSB], (w_it_lo == '0)};
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        S_DONE: begin
          if (flush || out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_hi    = r_out_hi;
  assign flags_out = r_flags;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=16): vector table plus hold, flush and
// mid-operation reset sequences.
module tb_multicycle_alu;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;
  localparam logic [3:0] OP_CB   = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ASR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [15:0] out_hi;
  logic [4:0]  flags_out;

  int checks = 0;
  int failures = 0;

  multicycle_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .flags_out (flags_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic [15:0] eh;
    logic [4:0]  ef;
    int          lat;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge on which out_valid is first seen.
  task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic rdy_seen);
    int guard;
    guard = 0;
    rdy_seen = 1'b0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    op = o;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 16'hDEAD;
    in_b = 16'hBEEF;
    lat = 1;
    if (in_ready) rdy_seen = 1'b1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic rdy;
    logic [15:0] held_out;

    vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 5'b01010, 1};
    vecs[1]  = '{OP_SUB,  16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 5'b00110, 1};
    vecs[2]  = '{OP_CMP,  16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 5'b00110, 1};
    vecs[3]  = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 16'h0001, 5'b01101, 17};
    vecs[4]  = '{OP_DIVU, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 5'b00000, 17};
    vecs[5]  = '{OP_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 5'b10010, 1};
    vecs[6]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b00101, 1};
    vecs[7]  = '{OP_INC,  16'h7FFF, 16'h5555, 16'h8000, 16'h0000, 5'b01010, 1};
    vecs[8]  = '{OP_DEC,  16'h0000, 16'h5555, 16'hFFFF, 16'h0000, 5'b00110, 1};
    vecs[9]  = '{OP_DEC,  16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 5'b01000, 1};
    vecs[10] = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b01000, 1};
    vecs[11] = '{OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 5'b00000, 1};
    vecs[12] = '{OP_OR,   16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 5'b00010, 1};
    vecs[13] = '{OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 5'b00001, 1};
    vecs[14] = '{OP_SB,   16'h0013, 16'h0000, 16'h0008, 16'h0000, 5'b00000, 1};
    vecs[15] = '{OP_CB,   16'h000F, 16'hFFFF, 16'h7FFF, 16'h0000, 5'b00000, 1};
    vecs[16] = '{OP_SHL,  16'h8001, 16'h0001, 16'h0002, 16'h0000, 5'b00100, 1};
    vecs[17] = '{OP_SHL,  16'h1234, 16'h0010, 16'h1234, 16'h0000, 5'b00000, 1};
    vecs[18] = '{OP_SHR,  16'h0003, 16'h0001, 16'h0001, 16'h0000, 5'b00100, 1};
    vecs[19] = '{OP_ASR,  16'h8004, 16'h0003, 16'hF000, 16'h0000, 5'b00110, 1};
    vecs[20] = '{OP_PASS, 16'h1234, 16'h8000, 16'h8000, 16'h0000, 5'b00010, 1};
    vecs[21] = '{OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 5'b01100, 17};
    vecs[22] = '{OP_DIVU, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 5'b00010, 17};
    vecs[23] = '{OP_DIVU, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 5'b00001, 17};

    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = OP_ADD;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", {16'h0, out}, 32'h0);
    chk("reset_out_hi", {16'h0, out_hi}, 32'h0);
    chk("reset_flags", {27'h0, flags_out}, 32'h0);
    chk("reset_valid_ready", {30'h0, out_valid, in_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rdy);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_out", i), {16'h0, out}, {16'h0, vecs[i].eo});
      chk($sformatf("v%0d_out_hi", i), {16'h0, out_hi}, {16'h0, vecs[i].eh});
      chk($sformatf("v%0d_flags", i), {27'h0, flags_out}, {27'h0, vecs[i].ef});
      chk($sformatf("v%0d_in_ready_low", i), {31'h0, rdy}, 32'h0);
      consume();
    end

    // Consumer stalls: result and handshake must hold.
    run_op(OP_ADD, 16'h1111, 16'h2222, lat, rdy);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d", k), {out_valid, in_ready, 9'h0, flags_out, out},
          {1'b1, 1'b0, 9'h0, 5'b00000, 16'h3333});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_idle", {30'h0, out_valid, in_ready}, 32'h1);
    run_op(OP_ADD, 16'h0002, 16'h0003, lat, rdy);
    chk("after_release_add", {lat[7:0], 8'h0, out}, {8'd1, 8'h0, 16'h0005});
    consume();

    // Flush during BUSY cycle 4: no result, IDLE next edge, result regs untouched.
    op = OP_MUL;
    in_a = 16'h0100;
    in_b = 16'h0100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {30'h0, out_valid, in_ready}, 32'h1);
    rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) rdy = 1'b1;
    end
    chk("flush_no_valid", {31'h0, rdy}, 32'h0);
    held_out = out;
    chk("flush_regs_kept", {out_hi, held_out}, {16'h0000, 16'h0005});

    // Asynchronous reset mid-BUSY.
    run_op(OP_DIVU, 16'h0064, 16'h0000, lat, rdy);
    consume();
    op = OP_MUL;
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {out_valid, in_ready, 9'h0, flags_out, out_hi | out}, 32'h0);
    chk("rst_mid_busy_out", {out_hi, out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_ASR, 16'h8000, 16'h000F, lat, rdy);
    chk("asr_after_reset", {lat[7:0], 3'h0, flags_out, out}, {8'd1, 3'h0, 5'b00010, 16'hFFFF});
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
